// File: rtl/axis_pixels_pack.sv
// Packs variable-count engine words into full-width AXI-Stream beats, flushing a keep-masked tail per packet.
// Define AXIS_PACK_HEADER_EN to emit one registered cfg_data header beat ahead of each packet's data.
module axis_pixels_pack #(
    parameter int WORD_WIDTH = 8,
    parameter int IN_WORDS   = 8,
    parameter int OUT_WORDS  = 8,
    parameter int HDR_WIDTH  = 32
) (
    input  logic                                aclk,
    input  logic                                rst,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [HDR_WIDTH-1:0]                cfg_data,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [IN_WORDS*WORD_WIDTH-1:0]      s_data,
    input  logic [$clog2(IN_WORDS+1)-1:0]       s_words,
    input  logic                                s_last,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [OUT_WORDS*WORD_WIDTH-1:0]     m_data,
    output logic [OUT_WORDS*WORD_WIDTH/8-1:0]   m_keep,
    output logic                                m_last
);
    localparam int CAP    = OUT_WORDS + IN_WORDS - 1;
    localparam int CNT_W  = $clog2(CAP + 1);
    localparam int DATA_W = OUT_WORDS * WORD_WIDTH;
    localparam int KEEP_W = DATA_W / 8;
    localparam int BUF_W  = CAP * WORD_WIDTH;
    localparam int IN_W   = IN_WORDS * WORD_WIDTH;
    localparam int BPW    = WORD_WIDTH / 8;
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PASS, S_FLUSH} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  count, count_next, count_kept;
    logic [BUF_W-1:0]  buffer, buffer_next, buffer_kept, push_data, push_mask;
    logic [IN_W-1:0]   in_mask;
    logic [DATA_W-1:0] tail_mask;
    logic [KEEP_W-1:0] tail_keep;
    logic              push, pop_full, final_beat;

`ifdef AXIS_PACK_HEADER_EN
    logic [HDR_WIDTH-1:0] hdr;

    always_ff @(posedge aclk) begin
        if (rst)
            hdr <= '0;
        else if (state == S_IDLE && cfg_valid)
            hdr <= cfg_data;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^cfg_data;
`endif

    always_comb begin
        tail_mask = '0;
        tail_keep = '0;
        in_mask   = '0;
        for (int j = 0; j < OUT_WORDS; j++) begin
            if (j < int'(count)) begin
                tail_mask[j*WORD_WIDTH +: WORD_WIDTH] = '1;
                tail_keep[j*BPW +: BPW] = '1;
            end
        end
        for (int j = 0; j < IN_WORDS; j++) begin
            if (j < int'(s_words))
                in_mask[j*WORD_WIDTH +: WORD_WIDTH] = '1;
        end
    end

    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_keep     = '0;
        m_last     = 1'b0;
        final_beat = (count <= OUT_CNT);
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
`ifdef AXIS_PACK_HEADER_EN
                if (cfg_valid) state_next = S_HEADER;
`else
                if (cfg_valid) state_next = S_PASS;
`endif
            end
`ifdef AXIS_PACK_HEADER_EN
            S_HEADER: begin
                m_valid = 1'b1;
                m_data[HDR_WIDTH-1:0] = hdr;
                m_keep = '1;
                if (m_ready) state_next = S_PASS;
            end
`endif
            S_PASS: begin
                s_ready = (count < OUT_CNT) | m_ready;
                m_valid = (count >= OUT_CNT);
                m_data  = buffer[DATA_W-1:0];
                m_keep  = '1;
                if (s_valid && s_ready && s_last) state_next = S_FLUSH;
            end
            S_FLUSH: begin
                m_valid = (count != '0);
                if (final_beat) begin
                    // Tail beat: zero the words past count so stale bits never leak out
                    m_last = m_valid;
                    m_data = buffer[DATA_W-1:0] & tail_mask;
                    m_keep = tail_keep;
                end else begin
                    m_data = buffer[DATA_W-1:0];
                    m_keep = '1;
                end
                if (!m_valid || (m_ready && m_last)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Pop shifts the buffer down first; the push then lands directly above what remains
    always_comb begin
        push        = s_valid & s_ready;
        pop_full    = m_valid & m_ready & ~m_last & (state == S_PASS || state == S_FLUSH);
        buffer_kept = pop_full ? (buffer >> DATA_W) : buffer;
        count_kept  = pop_full ? (count - OUT_CNT) : count;
        push_data   = BUF_W'(s_data & in_mask) << (int'(count_kept) * WORD_WIDTH);
        push_mask   = BUF_W'(in_mask) << (int'(count_kept) * WORD_WIDTH);
        buffer_next = buffer_kept;
        count_next  = count_kept;
        if (push) begin
            buffer_next = (buffer_kept & ~push_mask) | push_data;
            count_next  = count_kept + CNT_W'(s_words);
        end
        if (state_next == S_IDLE) begin
            buffer_next = '0;
            count_next  = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            buffer <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            buffer <= buffer_next;
        end
    end

    a_words_nonzero: assert property (@(posedge aclk) disable iff (rst)
        (s_valid && s_ready) |-> (s_words != '0));
    a_count_bound: assert property (@(posedge aclk) disable iff (rst)
        count <= CNT_W'(CAP));
endmodule

// File: tb/tb_axis_pixels_pack.sv
// Randomized bench for axis_pixels_pack against a packet-level chunking model; honours AXIS_PACK_HEADER_EN.
module tb_axis_pixels_pack;
    localparam int W     = 8;
    localparam int IW    = 8;
    localparam int OW    = 8;
    localparam int HW    = 32;
    localparam int DW    = OW * W;
    localparam int KW    = DW / 8;
    localparam int SWW   = $clog2(IW + 1);
    localparam int NPKT  = 30;
    localparam int LIMIT = 20000;

    logic            aclk = 1'b0;
    logic            rst;
    logic            cfg_valid, cfg_ready;
    logic [HW-1:0]   cfg_data;
    logic            s_valid, s_ready;
    logic [IW*W-1:0] s_data;
    logic [SWW-1:0]  s_words;
    logic            s_last;
    logic            m_valid, m_ready;
    logic [DW-1:0]   m_data;
    logic [KW-1:0]   m_keep;
    logic            m_last;

    axis_pixels_pack #(.WORD_WIDTH(W), .IN_WORDS(IW), .OUT_WORDS(OW), .HDR_WIDTH(HW)) dut (
        .aclk(aclk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_words(s_words), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t         expq[$];
    int            sizes[$];
    logic [W-1:0]  words[$];
    logic [HW-1:0] hdr;
    int            n_chk = 0, n_fail = 0;
    int            pkt, mode, bi, woff, phase, stall, cyc;
    logic          do_reset, prev_stall;
    beat_t         prev_beat, b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Expected output: optional header, then the packet's words cut into OW-word chunks
    task automatic model_packet();
        beat_t e;
        int n;
        n = words.size();
`ifdef AXIS_PACK_HEADER_EN
        e.data = '0;
        e.data[HW-1:0] = hdr;
        e.keep = '1;
        e.last = 1'b0;
        expq.push_back(e);
`endif
        for (int base = 0; base < n; base += OW) begin
            e.data = '0;
            e.keep = '0;
            for (int j = 0; j < OW && base + j < n; j++) begin
                e.data[j*W +: W] = words[base + j];
                e.keep[j*(W/8) +: W/8] = '1;
            end
            e.last = (base + OW >= n);
            expq.push_back(e);
        end
    endtask

    task automatic new_packet();
        int nb, total;
        sizes.delete();
        words.delete();
        hdr = HW'($urandom);
        case (pkt)
            0: begin mode = 1; sizes = '{8, 8}; hdr = 32'hA5; end
            1: begin mode = 0; sizes = '{3, 3, 1}; end
            2: begin mode = 2; sizes = '{8, 8, 8, 8, 8}; end
            3: begin mode = 1; sizes = '{5, 5, 8, 8}; end
            4: begin mode = 3; sizes = '{5, 8}; end
            default: begin
                mode = int'($urandom_range(0, 2));
                nb = int'($urandom_range(1, 5));
                for (int i = 0; i < nb; i++) sizes.push_back(int'($urandom_range(1, IW)));
            end
        endcase
        total = 0;
        foreach (sizes[i]) total += sizes[i];
        for (int i = 0; i < total; i++) words.push_back(pkt < 5 ? W'(i) : W'($urandom));
        bi = 0;
        woff = 0;
        phase = 0;
        model_packet();
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; s_valid = 1'b0; s_data = '0;
        s_words = SWW'(1); s_last = 1'b0; m_ready = 1'b0;
        stall = 0; cyc = 0; do_reset = 1'b0; prev_stall = 1'b0; prev_beat = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        rst = 1'b0;
        #1;
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_keep", m_keep, 0);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_cfg_ready", cfg_ready, 1);
        pkt = 0;
        new_packet();

        while ((pkt < NPKT || expq.size() != 0) && cyc < LIMIT) begin
            @(negedge aclk);
            cyc++;
            if (do_reset) begin
                rst = 1'b1; cfg_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
                @(negedge aclk);
                rst = 1'b0;
                #1;
                chk("midrst_m_valid", m_valid, 0);
                chk("midrst_s_ready", s_ready, 0);
                chk("midrst_cfg_ready", cfg_ready, 1);
                expq.delete();
                prev_stall = 1'b0;
                do_reset = 1'b0;
                pkt++;
                if (pkt < NPKT) new_packet();
                continue;
            end

            if (stall > 0) begin
                m_ready = 1'b0;
                stall--;
            end else if (mode == 1 || mode == 3) m_ready = 1'b1;
            else m_ready = ($urandom_range(0, 3) != 0);
            cfg_valid = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_words = SWW'(1);
            for (int j = 0; j < IW; j++) s_data[j*W +: W] = W'($urandom);
            if (pkt < NPKT) begin
                if (phase == 0) begin
                    cfg_valid = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                    cfg_data = hdr;
                end else begin
                    s_valid = (mode != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    s_words = SWW'(sizes[bi]);
                    for (int j = 0; j < sizes[bi]; j++) s_data[j*W +: W] = words[woff + j];
                    s_last = (bi == sizes.size() - 1);
                end
            end
            #1;

            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_beat.data);
                chk("hold_keep", m_keep, prev_beat.keep);
                chk("hold_last", m_last, prev_beat.last);
            end
            if (m_valid && !m_ready) chk("stall_s_ready", s_ready, 0);
            prev_stall = m_valid && !m_ready;
            prev_beat = '{data: m_data, keep: m_keep, last: m_last};

            if (m_valid && m_ready) begin
                chk("beat_expected", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    b = expq.pop_front();
                    chk("m_data", m_data, b.data);
                    chk("m_keep", m_keep, b.keep);
                    chk("m_last", m_last, b.last);
                end
            end
            if (cfg_valid && cfg_ready) phase = 1;
            if (s_valid && s_ready) begin
                woff += sizes[bi];
                bi++;
                if (mode == 2 && bi == 1) stall = 20;
                if (mode == 3 && bi == 1) do_reset = 1'b1;
                else if (bi == sizes.size()) begin
                    pkt++;
                    if (pkt < NPKT) new_packet();
                    else phase = 0;
                end
            end
        end

        chk("timeout", cyc >= LIMIT, 0);
        chk("leftover_beats", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
